fir_y_buffer: RTL and testbench

Output-side stage placed directly downstream of the FIR core's y[n] AXI-Stream master. It accepts 32-bit filter results, narrows them to the output width, and buffers them in a small first-word-fall-through FIFO so the FIR core is not stalled by a slow consumer. It also counts samples against the programmed data length and flags framing errors.

---
 rtl/fir_y_buffer.sv | 149 ++++++++++++++
 tb/tb_fir_y_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fir_y_buffer.sv
// Output stage for the FIR y[n] stream: narrows samples, buffers them in a FWFT FIFO,
// counts beats against cfg_length and flags framing errors. Define FIR_Y_SAT_EN for saturating narrowing.
module fir_y_buffer #(
    parameter int pDATA_WIDTH = 32,
    parameter int pOUT_WIDTH  = 16,
    parameter int pDEPTH      = 8
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pOUT_WIDTH-1:0]  m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    input  logic [31:0]            cfg_length,
    input  logic                   clr,
    output logic [31:0]            sample_cnt,
    output logic                   done,
    output logic                   err_early_last,
    output logic                   err_missing_last,
    output logic                   err_sat
);

    localparam int AW = $clog2(pDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [AW:0]           wr_ptr, rd_ptr;
    logic [pOUT_WIDTH:0]   mem [pDEPTH];
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;
    logic [pOUT_WIDTH-1:0] narrow;
    logic                  clip;
    logic [31:0]           beat_n;
    logic                  len_set, len_hit, terminal, last_flag;

    // Full when the wrap bits differ and the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign s_tready = (state_q != ST_DONE) && !fifo_full;
    assign m_tvalid = !fifo_empty;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    assign beat_n    = sample_cnt + 32'd1;
    assign len_set   = (cfg_length != 32'd0);
    assign len_hit   = len_set && (beat_n == cfg_length);
    assign terminal  = s_tlast || len_hit;
    assign last_flag = terminal;

`ifdef FIR_Y_SAT_EN
    logic [pDATA_WIDTH-pOUT_WIDTH:0] top_bits;

    // Sample fits iff every bit above the output sign bit matches it.
    always_comb begin
        top_bits = s_tdata[pDATA_WIDTH-1:pOUT_WIDTH-1];
        clip     = !((&top_bits) || !(|top_bits));
        narrow   = s_tdata[pOUT_WIDTH-1:0];
        if (clip) begin
            narrow = s_tdata[pDATA_WIDTH-1] ? {1'b1, {(pOUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(pOUT_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            err_sat <= 1'b0;
        end else if (clr) begin
            err_sat <= 1'b0;
        end else if (push && clip) begin
            err_sat <= 1'b1;
        end
    end
`else
    logic unused_tdata;

    assign unused_tdata = ^s_tdata;
    assign clip         = 1'b0;
    assign narrow       = s_tdata[pOUT_WIDTH-1:0];
    assign err_sat      = 1'b0;
`endif

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; pointers alone define validity, and the read mux
    // forces zero when empty so stale or X contents never reach m_tdata.
    always_ff @(posedge axis_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {last_flag, narrow};
    end

    always_comb begin
        {m_tlast, m_tdata} = '0;
        if (!fifo_empty) {m_tlast, m_tdata} = mem[rd_ptr[AW-1:0]];
    end

    // NOTE: default the next state first so every path assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (push) state_d = terminal ? ST_DONE : ST_RUN;
            ST_RUN:  if (push && terminal) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (clr) state_d = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q          <= ST_IDLE;
            sample_cnt       <= '0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                sample_cnt       <= '0;
                err_early_last   <= 1'b0;
                err_missing_last <= 1'b0;
            end else if (push) begin
                sample_cnt <= beat_n;
                if (s_tlast && len_set && (beat_n < cfg_length)) err_early_last <= 1'b1;
                if (!s_tlast && len_hit) err_missing_last <= 1'b1;
            end
        end
    end

    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_fir_y_buffer.sv
// Directed bench for fir_y_buffer: framing, back-pressure, error flags, narrowing and async reset.
module tb_fir_y_buffer;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [15:0] m_tdata;
    logic [31:0] cfg_length, sample_cnt;
    logic        clr, done, err_early_last, err_missing_last, err_sat;

    int n_vec = 0;
    int n_err = 0;

    fir_y_buffer #(.pDATA_WIDTH(32), .pOUT_WIDTH(16), .pDEPTH(8)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
        .cfg_length(cfg_length), .clr(clr), .sample_cnt(sample_cnt), .done(done),
        .err_early_last(err_early_last), .err_missing_last(err_missing_last), .err_sat(err_sat)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        bit ok = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = s_tready;
            tick();
        end
        if (!ok) check("push_tready", {31'd0, s_tready}, 32'd1);
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [15:0] d, input logic l);
        for (int i = 0; i < 40 && !m_tvalid; i++) tick();
        check({tag, "_valid"}, {31'd0, m_tvalid}, 32'd1);
        check({tag, "_data"}, {16'd0, m_tdata}, {16'd0, d});
        check({tag, "_last"}, {31'd0, m_tlast}, {31'd0, l});
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        axis_rst_n = 1'b0; s_tvalid = 0; s_tdata = 0; s_tlast = 0;
        m_tready = 0; cfg_length = 0; clr = 0;
        repeat (3) tick();
        check("rst_tready", {31'd0, s_tready}, 32'd1);
        check("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_mdata", {16'd0, m_tdata}, 32'd0);
        check("rst_mlast", {31'd0, m_tlast}, 32'd0);
        check("rst_cnt", sample_cnt, 32'd0);
        check("rst_flags", {28'd0, done, err_early_last, err_missing_last, err_sat}, 32'd0);
        axis_rst_n = 1'b1;
        tick();

        // Normal frame of four with tlast on the fourth, checking one-cycle latency.
        cfg_length = 4;
        push(32'd1, 1'b0);
        check("lat_valid", {31'd0, m_tvalid}, 32'd1);
        check("lat_data", {16'd0, m_tdata}, 32'd1);
        push(32'd2, 1'b0);
        push(32'd3, 1'b0);
        check("f1_not_done", {31'd0, done}, 32'd0);
        push(32'd4, 1'b1);
        check("f1_done", {31'd0, done}, 32'd1);
        check("f1_cnt", sample_cnt, 32'd4);
        check("f1_tready", {31'd0, s_tready}, 32'd0);
        check("f1_errs", {29'd0, err_early_last, err_missing_last, err_sat}, 32'd0);
        pop("f1_b1", 16'd1, 1'b0);
        pop("f1_b2", 16'd2, 1'b0);
        pop("f1_b3", 16'd3, 1'b0);
        pop("f1_b4", 16'd4, 1'b1);
        check("f1_empty", {31'd0, m_tvalid}, 32'd0);
        pulse_clr();
        check("f1_clr_done", {31'd0, done}, 32'd0);
        check("f1_clr_cnt", sample_cnt, 32'd0);

        // Back-pressure: fill all eight entries, then interleave pops and pushes.
        cfg_length = 0;
        for (int i = 0; i < 8; i++) push(32'd100 + i, 1'b0);
        check("full_tready", {31'd0, s_tready}, 32'd0);
        check("full_cnt", sample_cnt, 32'd8);
        pop("bp_b0", 16'd100, 1'b0);
        push(32'd108, 1'b0);
        pop("bp_b1", 16'd101, 1'b0);
        push(32'd109, 1'b1);
        check("bp_cnt", sample_cnt, 32'd10);
        for (int i = 2; i < 10; i++) pop("bp_drain", 16'd100 + i[15:0], i == 9);
        check("bp_empty", {31'd0, m_tvalid}, 32'd0);
        pulse_clr();

        // Early tlast against cfg_length=5.
        cfg_length = 5;
        push(32'd21, 1'b0);
        push(32'd22, 1'b0);
        push(32'd23, 1'b1);
        check("early_flag", {31'd0, err_early_last}, 32'd1);
        check("early_miss", {31'd0, err_missing_last}, 32'd0);
        check("early_done", {31'd0, done}, 32'd1);
        pop("early_b1", 16'd21, 1'b0);
        pop("early_b2", 16'd22, 1'b0);
        pop("early_b3", 16'd23, 1'b1);
        pulse_clr();
        check("early_clr", {30'd0, err_early_last, done}, 32'd0);
        check("early_tready", {31'd0, s_tready}, 32'd1);

        // Missing tlast: beat cfg_length closes the frame and is marked last.
        cfg_length = 3;
        push(32'd7, 1'b0);
        push(32'd8, 1'b0);
        push(32'd9, 1'b0);
        check("miss_flag", {31'd0, err_missing_last}, 32'd1);
        check("miss_early", {31'd0, err_early_last}, 32'd0);
        check("miss_tready", {31'd0, s_tready}, 32'd0);
        pop("miss_b1", 16'd7, 1'b0);
        pop("miss_b2", 16'd8, 1'b0);
        pop("miss_b3", 16'd9, 1'b1);
        pulse_clr();
        check("miss_clr", {31'd0, err_missing_last}, 32'd0);

        // Narrowing of out-of-range samples.
        cfg_length = 0;
        push(32'h0001_2345, 1'b0);
        push(32'hFFFE_0000, 1'b1);
`ifdef FIR_Y_SAT_EN
        pop("sat_pos", 16'h7FFF, 1'b0);
        pop("sat_neg", 16'h8000, 1'b1);
        check("sat_flag", {31'd0, err_sat}, 32'd1);
`else
        pop("trunc_pos", 16'h2345, 1'b0);
        pop("trunc_neg", 16'h0000, 1'b1);
        check("sat_flag", {31'd0, err_sat}, 32'd0);
`endif
        pulse_clr();

        // Asynchronous reset with three entries buffered.
        push(32'd31, 1'b0);
        push(32'd32, 1'b0);
        push(32'd33, 1'b0);
        check("pre_rst_valid", {31'd0, m_tvalid}, 32'd1);
        #2 axis_rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, m_tvalid}, 32'd0);
        check("arst_cnt", sample_cnt, 32'd0);
        check("arst_mdata", {16'd0, m_tdata}, 32'd0);
        check("arst_tready", {31'd0, s_tready}, 32'd1);
        tick();
        axis_rst_n = 1'b1;
        tick();
        check("post_rst_valid", {31'd0, m_tvalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
